// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline control: FSM encoding,
// default MUL/DIV occupancy and the hard-wired zero register index.
package riscv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hz_state_t;

    localparam int MULDIV_LAT_DEFAULT = 4;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating performance counter with synchronous clear and increment enable.
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, taken-branch and multi-cycle MUL/DIV hazards.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rd_E,
    input  logic             MemRead_E,
    input  logic             PCSrc_E,
    input  logic             MulDiv_E,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_M,
    output logic             Busy,
    output logic             MulDiv_Done,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 2);

    hz_state_t  state;
    hz_state_t  state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       load_use;

    assign load_use = MemRead_E && (Rd_E != REG_X0) &&
                      ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // Busy is the state register itself, so it stays visible during reset.
    assign Busy = (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (MulDiv_E) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A MUL/DIV in E cannot also be a branch or a load, so its start wins outright.
    always_comb begin
        Stall_F     = 1'b0;
        Stall_D     = 1'b0;
        Stall_E     = 1'b0;
        Flush_D     = 1'b0;
        Flush_E     = 1'b0;
        Flush_M     = 1'b0;
        MulDiv_Done = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (MulDiv_E) begin
                        Stall_F = 1'b1;
                        Stall_D = 1'b1;
                        Stall_E = 1'b1;
                        Flush_M = 1'b1;
                    end else if (PCSrc_E) begin
                        Flush_D = 1'b1;
                        Flush_E = 1'b1;
                    end else if (load_use) begin
                        Stall_F = 1'b1;
                        Stall_D = 1'b1;
                        Flush_E = 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        Stall_F = 1'b1;
                        Stall_D = 1'b1;
                        Stall_E = 1'b1;
                        Flush_M = 1'b1;
                    end else begin
                        MulDiv_Done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Flush_D is only ever raised by a taken branch, so it is the branch-flush event.
    hazard_perf_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (Stall_D),
        .count (StallCnt)
    );

    hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (Flush_D),
        .count (FlushCnt)
    );
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; expected control vectors go through a scoreboard queue.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1_D;
    logic [4:0] Rs2_D;
    logic [4:0] Rd_E;
    logic       MemRead_E;
    logic       PCSrc_E;
    logic       MulDiv_E;

    logic Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, Busy, MulDiv_Done;
    logic [31:0] StallCnt, FlushCnt;

    logic s_Stall_F, s_Stall_D, s_Stall_E, s_Flush_D, s_Flush_E, s_Flush_M, s_Busy, s_Done;
    logic [3:0] s_StallCnt, s_FlushCnt;

    // Vector layout: {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, Busy, MulDiv_Done}
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_LU   = 8'b1100_1000;
    localparam logic [7:0] E_BR   = 8'b0001_1000;
    localparam logic [7:0] E_MD0  = 8'b1110_0100;
    localparam logic [7:0] E_MDB  = 8'b1110_0110;
    localparam logic [7:0] E_DONE = 8'b0000_0011;
    localparam logic [7:0] E_BUSY = 8'b0000_0010;

    logic [7:0] exp_q[$];
    int checks;
    int errors;
    int m_stall;
    int m_flush;

    hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_E(Rd_E),
        .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E), .MulDiv_E(MulDiv_E),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
        .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M),
        .Busy(Busy), .MulDiv_Done(MulDiv_Done),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_E(Rd_E),
        .MemRead_E(MemRead_E), .PCSrc_E(PCSrc_E), .MulDiv_E(MulDiv_E),
        .Stall_F(s_Stall_F), .Stall_D(s_Stall_D), .Stall_E(s_Stall_E),
        .Flush_D(s_Flush_D), .Flush_E(s_Flush_E), .Flush_M(s_Flush_M),
        .Busy(s_Busy), .MulDiv_Done(s_Done),
        .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int perf(input int v);
`ifdef HAZARD_PERF_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic set_idle();
        Rs1_D = 5'd0; Rs2_D = 5'd0; Rd_E = 5'd0;
        MemRead_E = 1'b0; PCSrc_E = 1'b0; MulDiv_E = 1'b0;
    endtask

    // Called just after a rising edge with inputs already applied.
    task automatic step(input logic [7:0] exp, input string name);
        logic [7:0] got;
        logic [7:0] want;
        exp_q.push_back(exp);
        @(negedge clk);
        got  = {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M, Busy, MulDiv_Done};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s outputs got %b want %b", name, got, want);
        end
        checks++;
        if (StallCnt !== 32'(perf(m_stall))) begin
            errors++;
            $display("FAIL %s StallCnt got %0d want %0d", name, StallCnt, perf(m_stall));
        end
        checks++;
        if (FlushCnt !== 32'(perf(m_flush))) begin
            errors++;
            $display("FAIL %s FlushCnt got %0d want %0d", name, FlushCnt, perf(m_flush));
        end
        checks++;
        if (s_StallCnt !== 4'(perf(sat15(m_stall)))) begin
            errors++;
            $display("FAIL %s sat StallCnt got %0d want %0d", name, s_StallCnt, perf(sat15(m_stall)));
        end
        if (reset) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (want[6]) m_stall++;
            if (want[4]) m_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        MulDiv_E = 1'b1; PCSrc_E = 1'b1;
        step(E_NONE, "reset_forced_zero");
        reset = 1'b0;
        set_idle();
        step(E_NONE, "after_reset_idle");
    endtask

    task automatic test_load_use();
        logic [7:0] e;
        set_idle(); MemRead_E = 1'b1; Rd_E = 5'd5; Rs1_D = 5'd5;
        step(E_LU, "load_use_rs1");
        set_idle();
        step(E_NONE, "load_use_one_cycle");
        MemRead_E = 1'b1; Rd_E = 5'd0; Rs1_D = 5'd0;
        step(E_NONE, "load_use_x0");
        set_idle(); MemRead_E = 1'b1; Rd_E = 5'd7; Rs2_D = 5'd7; Rs1_D = 5'd3;
        step(E_LU, "load_use_rs2");
        set_idle(); Rd_E = 5'd7; Rs1_D = 5'd7;
        step(E_NONE, "no_load_no_stall");
        for (int i = 0; i < 10; i++) begin
            MemRead_E = 1'($urandom_range(0, 1));
            Rd_E  = 5'($urandom_range(0, 3));
            Rs1_D = 5'($urandom_range(0, 3));
            Rs2_D = 5'($urandom_range(0, 3));
            e = (MemRead_E && Rd_E != 5'd0 && (Rd_E == Rs1_D || Rd_E == Rs2_D)) ? E_LU : E_NONE;
            step(e, "load_use_random");
        end
        set_idle();
        step(E_NONE, "load_use_drain");
    endtask

    task automatic test_branch();
        set_idle(); PCSrc_E = 1'b1; MemRead_E = 1'b1; Rd_E = 5'd9; Rs1_D = 5'd9;
        step(E_BR, "branch_over_load_use");
        set_idle(); PCSrc_E = 1'b1;
        step(E_BR, "branch_alone");
        set_idle();
        step(E_NONE, "branch_drain");
    endtask

    task automatic test_muldiv();
        set_idle(); MulDiv_E = 1'b1;
        step(E_MD0, "md_c0_start");
        PCSrc_E = 1'b1; MemRead_E = 1'b1; Rd_E = 5'd4; Rs1_D = 5'd4;
        step(E_MDB, "md_c1_ignore_hazards");
        set_idle(); MulDiv_E = 1'b1;
        step(E_MDB, "md_c2");
        step(E_DONE, "md_c3_done");
        step(E_MD0, "md_b2b_c0");
        step(E_MDB, "md_b2b_c1");
        step(E_MDB, "md_b2b_c2");
        step(E_DONE, "md_b2b_c3_done");
        set_idle();
        step(E_NONE, "md_drain");
    endtask

    task automatic test_reset_mid();
        set_idle(); MulDiv_E = 1'b1;
        step(E_MD0, "rmid_c0");
        step(E_MDB, "rmid_c1");
        reset = 1'b1;
        step(E_BUSY, "rmid_reset_cycle");
        reset = 1'b0; MulDiv_E = 1'b0;
        step(E_NONE, "rmid_after_reset");
        MulDiv_E = 1'b1;
        step(E_MD0, "rmid_fresh_c0");
        step(E_MDB, "rmid_fresh_c1");
        step(E_MDB, "rmid_fresh_c2");
        step(E_DONE, "rmid_fresh_c3");
        set_idle();
        step(E_NONE, "rmid_drain");
    endtask

    task automatic test_perf();
        reset = 1'b1; set_idle();
        step(E_NONE, "perf_clear");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            MemRead_E = 1'b1; Rd_E = 5'd10; Rs2_D = 5'd10;
            step(E_LU, "perf_load_use");
            set_idle();
            step(E_NONE, "perf_gap");
        end
        MulDiv_E = 1'b1;
        step(E_MD0, "perf_md_c0");
        step(E_MDB, "perf_md_c1");
        step(E_MDB, "perf_md_c2");
        step(E_DONE, "perf_md_c3");
        set_idle(); PCSrc_E = 1'b1;
        step(E_BR, "perf_br1");
        set_idle();
        step(E_NONE, "perf_gap2");
        PCSrc_E = 1'b1;
        step(E_BR, "perf_br2");
        set_idle();
        step(E_NONE, "perf_settle");
        checks++;
        if (StallCnt !== 32'(perf(6))) begin
            errors++;
            $display("FAIL perf_stall_total got %0d want %0d", StallCnt, perf(6));
        end
        checks++;
        if (FlushCnt !== 32'(perf(2))) begin
            errors++;
            $display("FAIL perf_flush_total got %0d want %0d", FlushCnt, perf(2));
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1; set_idle();
        step(E_NONE, "sat_clear");
        reset = 1'b0;
        MemRead_E = 1'b1; Rd_E = 5'd1; Rs1_D = 5'd1;
        for (int i = 0; i < 20; i++) step(E_LU, "sat_stall");
        set_idle();
        step(E_NONE, "sat_settle");
        checks++;
        if (s_StallCnt !== 4'(perf(15))) begin
            errors++;
            $display("FAIL sat_hold got %0d want %0d", s_StallCnt, perf(15));
        end
        checks++;
        if (StallCnt !== 32'(perf(20))) begin
            errors++;
            $display("FAIL wide_count got %0d want %0d", StallCnt, perf(20));
        end
    endtask

    initial begin
        checks = 0; errors = 0; m_stall = 0; m_flush = 0;
        reset = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_reset_mid();
        test_perf();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller: the stall/flush side of operand forwarding in the 5-stage RISC-V core. Forwarding resolves RAW hazards by bypassing results. This block handles what bypassing cannot:
- load-use hazards;
- control hazards from taken branches/jumps resolved in E;
- multi-cycle MUL/DIV occupancy of E.

It drives the stall enables and flush (bubble) controls of the F/D, D/E and E/M pipeline registers.

## Interface
Parameters:
- MULDIV_LAT, 4, total cycles a MUL/DIV instruction occupies E (legal range 2..16)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- Rs1_D, Rs2_D  in  5 each  source registers of instruction in D
- Rd_E  in  5  destination register of instruction in E
- MemRead_E  in  1  instruction in E is a load
- PCSrc_E  in  1  taken branch/jump resolved in E
- MulDiv_E  in  1  instruction in E is MUL/DIV (held high while it sits in E)
- Stall_F, Stall_D, Stall_E  out  1 each  hold PC / F-D / D-E registers
- Flush_D, Flush_E, Flush_M  out  1 each  clear F-D / D-E / E-M registers to NOP
- Busy  out  1  registered; 1 while FSM in BUSY
- MulDiv_Done  out  1  MUL/DIV result valid in E this cycle
- StallCnt, FlushCnt  out  CNT_W each  performance counters

## Operation
- FSM states: IDLE, BUSY. 4-bit down-counter cnt.
- Load-use, evaluated only in IDLE: MemRead_E & (Rd_E != 0) & (Rd_E == Rs1_D | Rd_E == Rs2_D).
  - Effect: Stall_F = Stall_D = 1, Flush_E = 1 (one bubble).
- Branch, evaluated only in IDLE: PCSrc_E = 1.
  - Effect: Flush_D = Flush_E = 1.
  - Branch has priority over load-use. The instruction in D is wrong-path, so Stall_F = Stall_D = 0.
- MUL/DIV start: IDLE & MulDiv_E.
  - Same cycle: Stall_F = Stall_D = Stall_E = 1, Flush_M = 1.
  - Load cnt = MULDIV_LAT-2; next state BUSY.
- BUSY with cnt != 0:
  - Stall_F = Stall_D = Stall_E = Flush_M = 1.
  - cnt decrements.
  - MulDiv_E, PCSrc_E and load-use inputs are ignored.
- BUSY with cnt == 0:
  - MulDiv_Done = 1; all stalls/flushes 0.
  - Next state IDLE.
  - MulDiv_E still high this cycle is the same instruction and is not a new start.
- Back-to-back MUL/DIV: the next MulDiv_E seen in IDLE starts a new sequence.
- Reset, including mid-BUSY: next edge forces state IDLE, cnt 0, Busy 0, counters 0.
  - While reset is high, all combinational outputs are forced 0.

## Timing
- Load-use and branch controls are combinational, same cycle as the condition.
- MUL/DIV entering E in cycle T (MULDIV_LAT = L):
  - stalls asserted T..T+L-2 (L-1 cycles);
  - Busy = 1 in T+1..T+L-1;
  - MulDiv_Done = 1 in T+L-1 only;
  - next instruction enters E at T+L.
- Every output is 0 in the cycle after reset deasserts until its condition occurs.
- Counters update on the edge following the counted cycle.

## Configuration
- HAZARD_PERF_EN defined:
  - StallCnt increments each cycle Stall_D = 1.
  - FlushCnt increments each cycle PCSrc-driven Flush_D = 1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- HAZARD_PERF_EN undefined: no counter flops; StallCnt = FlushCnt = 0 constantly.

## Structure
- Shared package riscv_pkg holds:
  - FSM state encoding (IDLE = 1'b0, BUSY = 1'b1);
  - default MULDIV_LAT;
  - x0 register index constant.
- One sub-module: hazard_perf_cnt, a CNT_W saturating counter with sync clear and increment enable, instantiated twice under HAZARD_PERF_EN.

## Test plan
- Load-use:
  - MemRead_E = 1, Rd_E = 5, Rs1_D = 5 -> Stall_F = Stall_D = Flush_E = 1 for exactly one cycle.
  - Same with Rd_E = 0 -> all outputs 0.
- Branch vs load-use: PCSrc_E = 1 together with a load-use match -> Flush_D = Flush_E = 1, Stall_F = Stall_D = 0.
- MUL/DIV, L = 4: MulDiv_E held high cycles 0..3 -> stalls and Flush_M in cycles 0-2, Busy in 1-3, MulDiv_Done in cycle 3 only. Second MulDiv_E in cycle 4 restarts the same sequence.
- Reset mid-op: reset high in BUSY cycle 2 -> next cycle Busy = 0, all outputs 0. MulDiv_E high after release -> fresh 4-cycle sequence.
- Perf counters, with HAZARD_PERF_EN: 3 load-use events + one L = 4 MUL/DIV -> StallCnt = 6; two taken branches -> FlushCnt = 2. Without the macro -> both 0.
- Saturation, CNT_W = 4: 20 stall cycles -> StallCnt holds at 15.
